ysyx_24080014_lsu: RTL and testbench

YSYX_24080014_LSU -- requirements
Module: ysyx_24080014_lsu

---
 rtl/ysyx_24080014_lsu_pkg.sv | 68 ++++++
 rtl/ysyx_24080014_lsu_ext.sv | 32 +++
 rtl/ysyx_24080014_lsu.sv | 179 +++++++++++++++++
 tb/tb_ysyx_24080014_lsu.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080014_lsu_pkg.sv
// ysyx_24080014_lsu_pkg
//   Shared definitions for the load/store unit: RV32 funct3 width encodings,
//   FSM state encodings, the default access timeout and small helpers for
//   store lane generation and alignment classification.
package ysyx_24080014_lsu_pkg;

    // RV32 load/store width and sign encodings
    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Default number of WAIT cycles before an access is aborted
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

    function automatic logic funct3_legal(input logic [2:0] funct3);
        logic legal;
        case (funct3)
            FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_BU, FUNCT3_HU: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Halfwords must sit on an even byte, words on a word boundary.
    function automatic logic funct3_misaligned(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            FUNCT3_H, FUNCT3_HU: mis = addr_lo[0];
            FUNCT3_W:            mis = |addr_lo;
            default:             mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte enables for a store; lanes shifted past bit 3 fall off the word.
    function automatic logic [3:0] store_wstrb(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 4'b0001 << addr_lo;
            2'b01:   strb = 4'b0011 << addr_lo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Right-aligned store data replicated into every lane so the strobes pick it.
    function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3[1:0])
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/ysyx_24080014_lsu_ext.sv
// ysyx_24080014_lsu_ext
//   Combinational load-data lane select and sign/zero extension.
//   Ports:
//     rdata   in  32  raw word returned by memory
//     funct3  in   3  load width/sign encoding
//     addr_lo in   2  byte offset of the load within the word
//     data    out 32  extended load result (0 for undefined funct3)
module ysyx_24080014_lsu_ext
    import ysyx_24080014_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        // Bring the addressed byte down to lane 0; bytes beyond the word read as zero.
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            FUNCT3_B:  data = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_H:  data = {{16{shifted[15]}}, shifted[15:0]};
            FUNCT3_W:  data = rdata;
            FUNCT3_BU: data = {24'b0, shifted[7:0]};
            FUNCT3_HU: data = {16'b0, shifted[15:0]};
            default:   data = 32'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu
//   Single-outstanding load/store unit between the EXU and a word-wide memory
//   port. FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE. Accesses that see no
//   response within TIMEOUT_CYC WAIT cycles complete with out_err = 1.
//   Optional feature macro: YSYX_24080014_LSU_MISALIGN_CHK_EN -- when defined,
//   misaligned H/HU/W accesses skip memory and complete with out_err = 1.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     in_valid/in_ready              request handshake from EXU
//     in_we, in_funct3, in_addr,     store flag, width/sign, byte address,
//     in_wdata                       right-aligned store data
//     mem_req_valid/mem_req_ready    memory request handshake
//     mem_we, mem_addr, mem_wdata,   word-aligned request fields
//     mem_wstrb
//     mem_rsp_valid, mem_rdata       memory response
//     out_valid/out_ready            writeback handshake
//     out_read_data, out_err         extended load data, fault flag
module ysyx_24080014_lsu
    import ysyx_24080014_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_we,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_read_data,
    output logic        out_err
);

    // Counter value on the last permitted WAIT cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        accept;
    logic        skip_mem;
    logic        req_active;
    logic        store_active;
    logic [31:0] ext_data;

    // Requests that can never reach memory are decided at accept time.
`ifdef YSYX_24080014_LSU_MISALIGN_CHK_EN
    assign skip_mem = !funct3_legal(in_funct3) ||
                      funct3_misaligned(in_funct3, in_addr[1:0]);
`else
    assign skip_mem = !funct3_legal(in_funct3);
`endif

    // rst_n gates in_ready so the EXU sees no acceptance while reset is held.
    assign in_ready = rst_n && (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;

    ysyx_24080014_lsu_ext u_ext (
        .rdata   (mem_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_q[1:0]),
        .data    (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        data_d     = data_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                // Any mem_rsp_valid seen here is a late reply to a timed-out access.
                if (accept) begin
                    we_d       = in_we;
                    funct3_d   = in_funct3;
                    addr_d     = in_addr;
                    wdata_d    = in_wdata;
                    wait_cnt_d = 8'd0;
                    data_d     = 32'd0;
                    err_d      = 1'b0;
                    if (skip_mem) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                // A response on the final WAIT cycle still counts as success.
                if (mem_rsp_valid) begin
                    state_d = ST_RESP;
                    data_d  = we_q ? 32'd0 : ext_data;
                    err_d   = 1'b0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                    data_d  = 32'd0;
                    err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wait_cnt_q <= 8'd0;
            data_q     <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // Request fields are forced to zero outside REQ so idle buses stay quiet.
    assign req_active    = (state_q == ST_REQ);
    assign store_active  = req_active && we_q;
    assign mem_req_valid = req_active;
    assign mem_we        = store_active;
    assign mem_addr      = req_active ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata     = store_active ? store_wdata(funct3_q, wdata_q) : 32'd0;
    assign mem_wstrb     = store_active ? store_wstrb(funct3_q, addr_q[1:0]) : 4'b0000;

    assign out_valid     = (state_q == ST_RESP);
    assign out_read_data = data_q;
    assign out_err       = err_q;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// tb_ysyx_24080014_lsu
//   Directed scoreboard bench for ysyx_24080014_lsu (TIMEOUT_CYC = 4).
//   Expected memory requests and writeback responses are queued by the
//   stimulus; negedge monitors pop and compare on each handshake.
module tb_ysyx_24080014_lsu;
    import ysyx_24080014_lsu_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_we;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_read_data;

    ysyx_24080014_lsu #(.TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_we         (in_we),
        .in_funct3     (in_funct3),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_read_data (out_read_data),
        .out_err       (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } out_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_exp_t;

    out_exp_t out_q[$];
    mem_exp_t mem_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory / consumer behaviour knobs for the next transaction
    int          cfg_ready_lat = 0;
    int          cfg_rsp_lat   = 1;   // WAIT cycle carrying the response; <= 0 means none
    int          cfg_out_lat   = 0;
    logic [31:0] cfg_rdata     = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    int          m_rdy_wait = 0;
    int          m_wcyc     = 0;
    int          m_cur_lat  = 0;
    logic [31:0] m_cur_data = 32'h0;
    logic        m_pv       = 1'b0;
    logic        m_pr       = 1'b0;

    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'hA5A5_A5A5;
        forever begin
            @(posedge clk);
            #2;
            if (m_pv && m_pr) begin
                m_wcyc     = 1;
                m_cur_lat  = cfg_rsp_lat;
                m_cur_data = cfg_rdata;
            end else if (m_wcyc > 0) begin
                m_wcyc++;
            end
            mem_rsp_valid = (m_wcyc > 0) && (m_wcyc == m_cur_lat);
            mem_rdata     = mem_rsp_valid ? m_cur_data : 32'hA5A5_A5A5;
            if (mem_req_valid) begin
                if (m_rdy_wait < cfg_ready_lat) begin
                    mem_req_ready = 1'b0;
                    m_rdy_wait++;
                end else begin
                    mem_req_ready = 1'b1;
                end
            end else begin
                mem_req_ready = 1'b0;
                m_rdy_wait    = 0;
            end
            m_pv = mem_req_valid;
            m_pr = mem_req_ready;
        end
    end

    // ---------------- writeback consumer ----------------
    int o_wait = 0;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (out_valid) begin
                if (o_wait < cfg_out_lat) begin
                    out_ready = 1'b0;
                    o_wait++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = 1'b0;
                o_wait    = 0;
            end
        end
    end

    // ---------------- monitors ----------------
    mem_exp_t    mon_me;
    out_exp_t    mon_oe;
    logic        pm_valid = 1'b0, pm_ready = 1'b0, pm_we = 1'b0;
    logic [31:0] pm_addr = 32'h0, pm_wdata = 32'h0;
    logic [3:0]  pm_wstrb = 4'h0;
    logic        po_valid = 1'b0, po_ready = 1'b0, po_err = 1'b0;
    logic [31:0] po_data = 32'h0;
    int          o_first = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_valid && pm_valid && !pm_ready) begin
                check1("req_hold_we", mem_we, pm_we);
                check("req_hold_addr", mem_addr, pm_addr);
                check("req_hold_wdata", mem_wdata, pm_wdata);
                check("req_hold_wstrb", {28'h0, mem_wstrb}, {28'h0, pm_wstrb});
                check1("in_ready_busy", in_ready, 1'b0);
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mem_unexpected: got request addr 0x%08h, want none", mem_addr);
                end else begin
                    mon_me = mem_q.pop_front();
                    check1("mem_we", mem_we, mon_me.we);
                    check("mem_addr", mem_addr, mon_me.addr);
                    check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, mon_me.wstrb});
                    if (mon_me.we) check("mem_wdata", mem_wdata, mon_me.wdata);
                end
            end
            pm_valid = mem_req_valid;
            pm_ready = mem_req_ready;
            pm_we    = mem_we;
            pm_addr  = mem_addr;
            pm_wdata = mem_wdata;
            pm_wstrb = mem_wstrb;

            if (out_valid && !po_valid) o_first = cyc;
            if (out_valid && po_valid && !po_ready) begin
                check("resp_hold_data", out_read_data, po_data);
                check1("resp_hold_err", out_err, po_err);
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_unexpected: got response data 0x%08h, want none",
                             out_read_data);
                end else begin
                    mon_oe = out_q.pop_front();
                    check("out_read_data", out_read_data, mon_oe.data);
                    check1("out_err", out_err, mon_oe.err);
                    if (mon_oe.lat >= 0) check("out_latency", o_first - mon_oe.acc, mon_oe.lat);
                end
            end
            po_valid = out_valid;
            po_ready = out_ready;
            po_data  = out_read_data;
            po_err   = out_err;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int acc);
        int n = 0;
        in_valid  = 1'b1;
        in_we     = we;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wdata;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, want 1", n);
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((out_q.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: got %0d pending responses after %0d cycles, want 0",
                     out_q.size(), n);
            out_q.delete();
            mem_q.delete();
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit mem_access,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                        input logic [31:0] rdata, input int rsp_lat, input int ready_lat,
                        input int out_lat, input logic [31:0] exp_data, input logic exp_err,
                        input int exp_lat);
        int       acc;
        out_exp_t oe;
        cfg_rdata     = rdata;
        cfg_rsp_lat   = rsp_lat;
        cfg_ready_lat = ready_lat;
        cfg_out_lat   = out_lat;
        if (mem_access)
            mem_q.push_back('{we: we, addr: {addr[31:2], 2'b00}, wdata: exp_wdata,
                              wstrb: exp_wstrb});
        issue(we, f3, addr, wdata, acc);
        oe.data = exp_data;
        oe.err  = exp_err;
        oe.lat  = exp_lat;
        oe.acc  = acc;
        out_q.push_back(oe);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_in_ready"}, in_ready, 1'b0);
        check1({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
        check1({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
        check1({tag, "_out_valid"}, out_valid, 1'b0);
        check1({tag, "_out_err"}, out_err, 1'b0);
        check({tag, "_out_read_data"}, out_read_data, 32'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish by %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_we     = 1'b0;
        in_funct3 = 3'b000;
        in_addr   = 32'h0;
        in_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("in_ready_after_reset", in_ready, 1'b1);

        // Sign-extended byte from the top lane
        xact(1'b0, FUNCT3_B, 32'h8000_0003, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h80FF_0000, 1, 0, 0, 32'hFFFF_FF80, 1'b0, 2);
        // Halfword store in the upper half
        xact(1'b1, FUNCT3_H, 32'h8000_0002, 32'h0000_1234, 1'b1, 32'h1234_1234, 4'b1100,
             32'hFFFF_FFFF, 1, 0, 0, 32'h0, 1'b0, 2);
        xact(1'b0, FUNCT3_BU, 32'h8000_0001, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h1234_80AB, 1, 0, 0, 32'h0000_0080, 1'b0, 2);
        xact(1'b0, FUNCT3_H, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h7FFF_8001, 1, 0, 0, 32'hFFFF_8001, 1'b0, 2);
        xact(1'b0, FUNCT3_HU, 32'h8000_0002, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'hBEEF_0000, 1, 0, 0, 32'h0000_BEEF, 1'b0, 2);
        xact(1'b0, FUNCT3_W, 32'h8000_0004, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'hDEAD_BEEF, 1, 0, 0, 32'hDEAD_BEEF, 1'b0, 2);
        xact(1'b1, FUNCT3_B, 32'h8000_0001, 32'h0000_00AB, 1'b1, 32'hABAB_ABAB, 4'b0010,
             32'hFFFF_FFFF, 1, 0, 0, 32'h0, 1'b0, 2);
        xact(1'b1, FUNCT3_W, 32'h8000_0008, 32'h1122_3344, 1'b1, 32'h1122_3344, 4'b1111,
             32'hFFFF_FFFF, 1, 0, 0, 32'h0, 1'b0, 2);

        // mem_req_ready held low for 5 cycles
        xact(1'b0, FUNCT3_W, 32'h8000_000C, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h0BAD_F00D, 1, 5, 0, 32'h0BAD_F00D, 1'b0, 7);
        // No response: abort after 4 WAIT cycles
        xact(1'b0, FUNCT3_W, 32'h8000_0010, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h1111_1111, 0, 0, 0, 32'h0, 1'b1, 5);
        // Timed out, then the reply shows up once the block is back in IDLE
        xact(1'b0, FUNCT3_W, 32'h8000_0014, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h2222_2222, 6, 0, 0, 32'h0, 1'b1, 5);
        xact(1'b0, FUNCT3_W, 32'h8000_0018, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h1357_2468, 1, 0, 0, 32'h1357_2468, 1'b0, 2);
        // Response on the final WAIT cycle wins over the timeout
        xact(1'b0, FUNCT3_W, 32'h8000_001C, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'hCAFE_F00D, 4, 0, 0, 32'hCAFE_F00D, 1'b0, 5);
        // out_ready low for 3 cycles
        xact(1'b0, FUNCT3_BU, 32'h8000_0002, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h00AB_0000, 1, 0, 3, 32'h0000_00AB, 1'b0, 2);
        // Undefined funct3 completes without memory access
        xact(1'b0, 3'b011, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'b0000,
             32'h0, 1, 0, 0, 32'h0, 1'b1, 0);
        xact(1'b1, 3'b111, 32'h8000_0000, 32'h5555_5555, 1'b0, 32'h0, 4'b0000,
             32'h0, 1, 0, 0, 32'h0, 1'b1, 0);

`ifdef YSYX_24080014_LSU_MISALIGN_CHK_EN
        xact(1'b0, FUNCT3_W, 32'h8000_0001, 32'h0, 1'b0, 32'h0, 4'b0000,
             32'h0102_0304, 1, 0, 0, 32'h0, 1'b1, 0);
        xact(1'b1, FUNCT3_H, 32'h8000_0003, 32'h0000_ABCD, 1'b0, 32'h0, 4'b0000,
             32'h0, 1, 0, 0, 32'h0, 1'b1, 0);
        xact(1'b0, FUNCT3_H, 32'h8000_0003, 32'h0, 1'b0, 32'h0, 4'b0000,
             32'h8011_2233, 1, 0, 0, 32'h0, 1'b1, 0);
`else
        xact(1'b0, FUNCT3_W, 32'h8000_0001, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h0102_0304, 1, 0, 0, 32'h0102_0304, 1'b0, 2);
        // Upper lane falls off the word
        xact(1'b1, FUNCT3_H, 32'h8000_0003, 32'h0000_ABCD, 1'b1, 32'hABCD_ABCD, 4'b1000,
             32'hFFFF_FFFF, 1, 0, 0, 32'h0, 1'b0, 2);
        xact(1'b0, FUNCT3_H, 32'h8000_0003, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h8011_2233, 1, 0, 0, 32'h0000_0080, 1'b0, 2);
`endif

        // Reset pulsed while waiting for a response: the access vanishes
        cfg_rsp_lat   = 0;
        cfg_ready_lat = 0;
        cfg_out_lat   = 0;
        mem_q.push_back('{we: 1'b0, addr: 32'h8000_0020, wdata: 32'h0, wstrb: 4'b0000});
        issue(1'b0, FUNCT3_W, 32'h8000_0020, 32'h0, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check1("in_ready_after_rst_wait", in_ready, 1'b1);
        check1("out_valid_after_rst_wait", out_valid, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        xact(1'b0, FUNCT3_B, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 4'b0000,
             32'h0000_00FF, 1, 0, 0, 32'hFFFF_FFFF, 1'b0, 2);

        repeat (5) @(posedge clk);
        #1;
        check("out_queue_drained", out_q.size(), 32'd0);
        check("mem_queue_drained", mem_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
